// File: rtl/riscv_decode_exec_unit.sv
// riscv_decode_exec_unit
// Decode-plus-execute slice of a multicycle RV32I-subset datapath
// (lw, sw, sub, xor, addi, srl, beq). The decode register captures the
// instruction fields in the ID phase; the execute register captures the
// ALU result, zero flag and branch decision in the EX phase. Both hold
// their contents in every other phase.
//
// Optional build macro: ALU_EXT_OPS_EN
//   When defined, the ALU also performs AND, OR, SLL and SRA.
//   When undefined, those codes produce a zero result.
module riscv_decode_exec_unit #(
    parameter logic [3:0] ID_STATE = 4'b0001,
    parameter logic [3:0] EX_STATE = 4'b0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  estado,
    input  logic [31:0] instrucao,
    input  logic [31:0] readdata1R,
    input  logic [31:0] readdata2R,
    input  logic        alusrc,
    input  logic [3:0]  alucontrol,
    input  logic        branch,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [11:0] immediate,
    output logic [2:0]  tipo,
    output logic        halt,
    output logic [31:0] aluresult2,
    output logic        aluresult1,
    output logic        pcsrc
);

    // Opcodes of the supported instruction classes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;

    // Instruction class codes reported on tipo
    localparam logic [2:0] T_R       = 3'b000;
    localparam logic [2:0] T_LOAD    = 3'b001;
    localparam logic [2:0] T_STORE   = 3'b010;
    localparam logic [2:0] T_BRANCH  = 3'b011;
    localparam logic [2:0] T_IARITH  = 3'b100;
    localparam logic [2:0] T_UNKNOWN = 3'b111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;
`ifdef ALU_EXT_OPS_EN
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0111;
`endif

    // Map an opcode to its instruction class
    function automatic logic [2:0] f_tipo(input logic [6:0] op);
        logic [2:0] t;
        case (op)
            OP_R:      t = T_R;
            OP_LOAD:   t = T_LOAD;
            OP_STORE:  t = T_STORE;
            OP_BRANCH: t = T_BRANCH;
            OP_IARITH: t = T_IARITH;
            default:   t = T_UNKNOWN;
        endcase
        return t;
    endfunction

    // Assemble the class-dependent 12-bit immediate; the branch form is the
    // byte offset already divided by two (bit 0 of the offset is implicit).
    function automatic logic [11:0] f_imm(input logic [31:0] inst);
        logic [11:0] imm;
        case (inst[6:0])
            OP_LOAD, OP_IARITH: imm = inst[31:20];
            OP_STORE:           imm = {inst[31:25], inst[11:7]};
            OP_BRANCH:          imm = {inst[31], inst[7], inst[30:25], inst[11:8]};
            default:            imm = 12'h000;
        endcase
        return imm;
    endfunction

    // 32-bit ALU; arithmetic wraps modulo 2^32, shifts use only B[4:0]
    function automatic logic [31:0] f_alu(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  ctl);
        logic [31:0]        res;
        logic signed [31:0] a_s;
        a_s = $signed(a);
        case (ctl)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_XOR: res = a ^ b;
            ALU_SRL: res = a >> b[4:0];
`ifdef ALU_EXT_OPS_EN
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLL: res = a << b[4:0];
            ALU_SRA: res = $unsigned(a_s >>> b[4:0]);
`endif
            default: res = 32'h0000_0000;
        endcase
        // a_s is only consumed by the optional arithmetic shift
        if (a_s == 32'sd0) res = res;
        return res;
    endfunction

    logic [6:0]  r_opcode;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [11:0] r_immediate;
    logic [2:0]  r_tipo;
    logic        r_halt;
    logic [31:0] r_aluresult;
    logic        r_zero;
    logic        r_pcsrc;

    logic [31:0] w_opb;
    logic [31:0] w_alu_res;
    logic        w_alu_zero;

    // Operand B selects the sign-extended decoded immediate or rs2
    assign w_opb      = alusrc ? {{20{r_immediate[11]}}, r_immediate} : readdata2R;
    assign w_alu_res  = f_alu(readdata1R, w_opb, alucontrol);
    assign w_alu_zero = (w_alu_res == 32'h0000_0000);

    // Decode register: capture fields, class and immediate in the ID phase.
    // An all-zero word has opcode 0, so it already decodes as unknown with a
    // zero immediate; halt only flags it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode    <= 7'd0;
            r_rd        <= 5'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_funct3    <= 3'd0;
            r_funct7    <= 7'd0;
            r_immediate <= 12'd0;
            r_tipo      <= 3'd0;
            r_halt      <= 1'b0;
        end else if (estado == ID_STATE) begin
            r_opcode    <= instrucao[6:0];
            r_rd        <= instrucao[11:7];
            r_rs1       <= instrucao[19:15];
            r_rs2       <= instrucao[24:20];
            r_funct3    <= instrucao[14:12];
            r_funct7    <= instrucao[31:25];
            r_immediate <= f_imm(instrucao);
            r_tipo      <= f_tipo(instrucao[6:0]);
            r_halt      <= (instrucao == 32'h0000_0000);
        end
    end

    // Execute register: capture ALU result, zero flag and branch decision
    // from the same edge in the EX phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aluresult <= 32'd0;
            r_zero      <= 1'b0;
            r_pcsrc     <= 1'b0;
        end else if (estado == EX_STATE) begin
            r_aluresult <= w_alu_res;
            r_zero      <= w_alu_zero;
            r_pcsrc     <= branch & w_alu_zero;
        end
    end

    assign opcode     = r_opcode;
    assign rd         = r_rd;
    assign rs1        = r_rs1;
    assign rs2        = r_rs2;
    assign funct3     = r_funct3;
    assign funct7     = r_funct7;
    assign immediate  = r_immediate;
    assign tipo       = r_tipo;
    assign halt       = r_halt;
    assign aluresult2 = r_aluresult;
    assign aluresult1 = r_zero;
    assign pcsrc      = r_pcsrc;

endmodule

// File: tb/tb_riscv_decode_exec_unit.sv
// Testbench for riscv_decode_exec_unit.
// Expected ALU outcomes are pushed to a scoreboard queue when an EX phase
// is driven and popped when the execute register has updated.
module tb_riscv_decode_exec_unit;

    localparam logic [3:0] ID   = 4'b0001;
    localparam logic [3:0] EX   = 4'b0010;
    localparam logic [3:0] IDLE = 4'b0000;

    logic        clk;
    logic        rst;
    logic [3:0]  estado;
    logic [31:0] instrucao;
    logic [31:0] readdata1R;
    logic [31:0] readdata2R;
    logic        alusrc;
    logic [3:0]  alucontrol;
    logic        branch;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] immediate;
    logic [2:0]  tipo;
    logic        halt;
    logic [31:0] aluresult2;
    logic        aluresult1;
    logic        pcsrc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        pc;
    } exp_t;
    exp_t sb[$];

    riscv_decode_exec_unit #(.ID_STATE(ID), .EX_STATE(EX)) dut (
        .clk(clk), .rst(rst), .estado(estado), .instrucao(instrucao),
        .readdata1R(readdata1R), .readdata2R(readdata2R), .alusrc(alusrc),
        .alucontrol(alucontrol), .branch(branch), .opcode(opcode), .rd(rd),
        .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .immediate(immediate), .tipo(tipo), .halt(halt),
        .aluresult2(aluresult2), .aluresult1(aluresult1), .pcsrc(pcsrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference ALU written from the operation table
    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] ctl);
        logic [31:0] r;
        r = 32'h0;
        if (ctl == 4'b0010) r = a + b;
        if (ctl == 4'b0110) r = a - b;
        if (ctl == 4'b0011) r = a ^ b;
        if (ctl == 4'b0101) for (int i = 0; i < 32; i++) r[i] = (i + b[4:0] < 32) ? a[i + b[4:0]] : 1'b0;
`ifdef ALU_EXT_OPS_EN
        if (ctl == 4'b0000) r = a & b;
        if (ctl == 4'b0001) r = a | b;
        if (ctl == 4'b0100) r = a << b[4:0];
        if (ctl == 4'b0111) for (int i = 0; i < 32; i++) r[i] = (i + b[4:0] < 32) ? a[i + b[4:0]] : a[31];
`endif
        return r;
    endfunction

    // One clock edge with estado = st, then return to an idle state code
    task automatic tick_state(input logic [3:0] st);
        @(negedge clk);
        estado = st;
        @(posedge clk);
        #1;
        estado = IDLE;
    endtask

    task automatic do_id(input logic [31:0] inst);
        instrucao = inst;
        tick_state(ID);
    endtask

    // Drive an EX phase, score it, and compare the popped expectation
    task automatic do_ex(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [11:0] imm, input logic [3:0] ctl,
                         input logic br);
        exp_t e;
        logic [31:0] opb;
        readdata1R = a;
        readdata2R = b;
        alusrc     = src;
        alucontrol = ctl;
        branch     = br;
        opb        = src ? {{20{imm[11]}}, imm} : b;
        e.res      = model_alu(a, opb, ctl);
        e.zero     = (e.res == 32'h0);
        e.pc       = br & e.zero;
        sb.push_back(e);
        tick_state(EX);
        e = sb.pop_front();
        checks++;
        if (aluresult2 !== e.res) begin
            errors++;
            $display("FAIL %s aluresult2: got %h expected %h", nm, aluresult2, e.res);
        end
        checks++;
        if (aluresult1 !== e.zero) begin
            errors++;
            $display("FAIL %s aluresult1: got %b expected %b", nm, aluresult1, e.zero);
        end
        checks++;
        if (pcsrc !== e.pc) begin
            errors++;
            $display("FAIL %s pcsrc: got %b expected %b", nm, pcsrc, e.pc);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({opcode, rd, rs1, rs2, funct3, funct7, immediate, tipo, halt, aluresult2, aluresult1, pcsrc} !== 78'd0) begin
            errors++;
            $display("FAIL reset_state: got nonzero outputs opcode=%h alu=%h", opcode, aluresult2);
        end
    endtask

    task automatic test_addi;
        do_id(32'h00700293);
        checks++;
        if ({tipo, rd, rs1, immediate, halt} !== {3'b100, 5'd5, 5'd0, 12'h007, 1'b0}) begin
            errors++;
            $display("FAIL addi_decode: got tipo=%b rd=%0d rs1=%0d imm=%h expected 100/5/0/007",
                     tipo, rd, rs1, immediate);
        end
        do_ex("addi", 32'd0, 32'hDEAD_BEEF, 1'b1, 12'h007, 4'b0010, 1'b0);
        checks++;
        if (aluresult2 !== 32'd7) begin
            errors++;
            $display("FAIL addi_result: got %h expected 00000007", aluresult2);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        estado = EX;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({opcode, rd, tipo, immediate, aluresult2, aluresult1, pcsrc} !== 62'd0) begin
            errors++;
            $display("FAIL async_reset: got opcode=%h rd=%0d alu=%h expected all 0", opcode, rd, aluresult2);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({opcode, aluresult2, aluresult1} !== 40'd0) begin
            errors++;
            $display("FAIL reset_hold: got opcode=%h alu=%h expected 0", opcode, aluresult2);
        end
        @(negedge clk);
        rst    = 1'b0;
        estado = IDLE;
    endtask

    task automatic test_sub;
        do_id(32'h402081B3);
        checks++;
        if ({tipo, funct7, rs1, rs2, rd, funct3, immediate} !== {3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 3'd0, 12'h000}) begin
            errors++;
            $display("FAIL sub_decode: got tipo=%b f7=%h rs1=%0d rs2=%0d rd=%0d imm=%h",
                     tipo, funct7, rs1, rs2, rd, immediate);
        end
        do_ex("sub", 32'd5, 32'd5, 1'b0, immediate, 4'b0110, 1'b0);
        checks++;
        if ({aluresult2, aluresult1, pcsrc} !== {32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_result: got %h/%b/%b expected 0/1/0", aluresult2, aluresult1, pcsrc);
        end
    endtask

    task automatic test_beq;
        do_id(32'h00208863);
        checks++;
        if ({tipo, immediate} !== {3'b011, 12'h008}) begin
            errors++;
            $display("FAIL beq_decode: got tipo=%b imm=%h expected 011/008", tipo, immediate);
        end
        do_ex("beq_taken", 32'd9, 32'd9, 1'b0, immediate, 4'b0110, 1'b1);
        checks++;
        if (pcsrc !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken_const: got %b expected 1", pcsrc);
        end
        do_ex("beq_not_taken", 32'd9, 32'd8, 1'b0, immediate, 4'b0110, 1'b1);
        checks++;
        if (pcsrc !== 1'b0) begin
            errors++;
            $display("FAIL beq_not_taken_const: got %b expected 0", pcsrc);
        end
    endtask

    task automatic test_store_negimm;
        do_id(32'h0020A423);
        checks++;
        if ({tipo, immediate} !== {3'b010, 12'h008}) begin
            errors++;
            $display("FAIL sw_decode: got tipo=%b imm=%h expected 010/008", tipo, immediate);
        end
        do_id(32'hFFC00293);
        checks++;
        if ({tipo, immediate} !== {3'b100, 12'hFFC}) begin
            errors++;
            $display("FAIL addi_neg_decode: got tipo=%b imm=%h expected 100/ffc", tipo, immediate);
        end
        do_ex("addi_neg", 32'd16, 32'd0, 1'b1, 12'hFFC, 4'b0010, 1'b0);
        checks++;
        if (aluresult2 !== 32'd12) begin
            errors++;
            $display("FAIL addi_neg_result: got %h expected 0000000c", aluresult2);
        end
    endtask

    task automatic test_srl_xor_hold;
        do_ex("srl", 32'h8000_0000, 32'd4, 1'b0, immediate, 4'b0101, 1'b0);
        checks++;
        if (aluresult2 !== 32'h0800_0000) begin
            errors++;
            $display("FAIL srl_result: got %h expected 08000000", aluresult2);
        end
        do_ex("xor", 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, immediate, 4'b0011, 1'b0);
        checks++;
        if (aluresult2 !== 32'h0000_FF00) begin
            errors++;
            $display("FAIL xor_result: got %h expected 0000ff00", aluresult2);
        end
        @(negedge clk);
        estado     = 4'b0101;
        instrucao  = 32'h402081B3;
        readdata1R = 32'h1234_5678;
        readdata2R = 32'h1234_5678;
        alucontrol = 4'b0110;
        branch     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({aluresult2, aluresult1, pcsrc, tipo, immediate} !== {32'h0000_FF00, 1'b0, 1'b0, 3'b100, 12'hFFC}) begin
            errors++;
            $display("FAIL hold: got alu=%h z=%b pc=%b tipo=%b imm=%h expected ff00/0/0/100/ffc",
                     aluresult2, aluresult1, pcsrc, tipo, immediate);
        end
        estado = IDLE;
    endtask

    task automatic test_halt_unknown;
        do_id(32'h0000_0000);
        checks++;
        if ({halt, tipo, immediate} !== {1'b1, 3'b111, 12'h000}) begin
            errors++;
            $display("FAIL halt_decode: got halt=%b tipo=%b imm=%h expected 1/111/000", halt, tipo, immediate);
        end
        do_id(32'hFFFF_F0B7);
        checks++;
        if ({halt, tipo, immediate, rd} !== {1'b0, 3'b111, 12'h000, 5'd1}) begin
            errors++;
            $display("FAIL unknown_decode: got halt=%b tipo=%b imm=%h rd=%0d expected 0/111/000/1",
                     halt, tipo, immediate, rd);
        end
    endtask

    task automatic test_sample_at_edge;
        @(negedge clk);
        estado    = ID;
        instrucao = 32'h0020A423;
        #3 instrucao = 32'h0000_4003;
        @(posedge clk);
        #1;
        estado = IDLE;
        checks++;
        if ({tipo, funct3, immediate} !== {3'b001, 3'b100, 12'h000}) begin
            errors++;
            $display("FAIL edge_sample: got tipo=%b f3=%b imm=%h expected 001/100/000", tipo, funct3, immediate);
        end
    endtask

    task automatic test_other_codes_random;
        logic [3:0] ctl;
        do_ex("code_0000", 32'h0000_00F0, 32'h0000_0FF0, 1'b0, immediate, 4'b0000, 1'b1);
        do_ex("code_1111", 32'd3, 32'd4, 1'b0, immediate, 4'b1111, 1'b0);
        for (int i = 0; i < 24; i++) begin
            ctl = 4'($urandom_range(0, 15));
            do_ex("random", $urandom, (i % 4 == 0) ? 32'd0 : $urandom, 1'b0, immediate, ctl, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst        = 1'b1;
        estado     = IDLE;
        instrucao  = 32'h0;
        readdata1R = 32'h0;
        readdata2R = 32'h0;
        alusrc     = 1'b0;
        alucontrol = 4'h0;
        branch     = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_addi();
        test_async_reset();
        test_sub();
        test_beq();
        test_store_negimm();
        test_srl_xor_hold();
        test_halt_unknown();
        test_sample_at_edge();
        test_other_codes_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
